// File: rtl/cs_pkg.sv
// Shared constants, types and helpers for the cs series-smoothing block.
package cs_pkg;
  localparam int N  = 9;
  localparam int XW = 8;
  localparam int YW = 10;
  localparam int SW = 12;
  localparam int NW = 13;

  typedef logic [XW-1:0] sample_t;
  typedef logic [SW-1:0] sum_t;
  typedef logic [NW-1:0] num_t;

  function automatic sample_t max2(input sample_t a, input sample_t b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/cs_approx.sv
// Largest window sample not exceeding the average: masked compares feeding a max-tree.
module cs_approx
  import cs_pkg::*;
(
  input  logic [N-1:0][XW-1:0] i_win,
  input  logic [XW-1:0]        i_avg,
  output logic [XW-1:0]        o_appr
);
  // Samples above the average become 0, which never wins because min <= avg.
  sample_t w_m [N];
  sample_t w_l1 [5];
  sample_t w_l2 [3];
  sample_t w_l3 [2];

  always_comb begin
    for (int k = 0; k < N; k++) begin
      w_m[k] = (i_win[k] <= i_avg) ? i_win[k] : '0;
    end
  end

  assign w_l1[0] = max2(w_m[0], w_m[1]);
  assign w_l1[1] = max2(w_m[2], w_m[3]);
  assign w_l1[2] = max2(w_m[4], w_m[5]);
  assign w_l1[3] = max2(w_m[6], w_m[7]);
  assign w_l1[4] = w_m[8];

  assign w_l2[0] = max2(w_l1[0], w_l1[1]);
  assign w_l2[1] = max2(w_l1[2], w_l1[3]);
  assign w_l2[2] = w_l1[4];

  assign w_l3[0] = max2(w_l2[0], w_l2[1]);
  assign w_l3[1] = w_l2[2];

  assign o_appr = max2(w_l3[0], w_l3[1]);
endmodule

// File: rtl/cs.sv
// Series smoother: 9-sample window, exact average, approximate value, registered result.
module cs
  import cs_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [XW-1:0] X,
  output logic [YW-1:0] Y
);
  logic [N-1:0][XW-1:0] r_win;
  logic [N-1:0][XW-1:0] w_elem;
  sum_t                 w_sum;
  sample_t              w_avg;
  sample_t              w_appr;
  num_t                 w_num;
  logic [YW-1:0]        r_y;

  function automatic sum_t ext(input sample_t v);
    return {{(SW-XW){1'b0}}, v};
  endfunction

  // floor(s/9) via s*7282/65536; the 2/65536 overshoot stays below the 1/9 margin for s <= 2295.
  function automatic sample_t div9(input sum_t s);
    logic [24:0] p;
    p = {13'd0, s} * 25'd7282;
    return p[23:16];
  endfunction

  // Post-shift window: the incoming sample is element 0.
  assign w_elem = {r_win[N-2:0], X};

  assign w_sum = ((ext(w_elem[0]) + ext(w_elem[1])) + (ext(w_elem[2]) + ext(w_elem[3])))
               + ((ext(w_elem[4]) + ext(w_elem[5])) + (ext(w_elem[6]) + ext(w_elem[7])))
               + ext(w_elem[8]);

  assign w_avg = div9(w_sum);

  cs_approx u_approx (
    .i_win  (w_elem),
    .i_avg  (w_avg),
    .o_appr (w_appr)
  );

  assign w_num = {1'b0, w_sum} + {2'b00, w_appr, 3'b000} + {5'd0, w_appr};

  // Output register stage
  always_ff @(posedge clk) begin
    if (reset) begin
      r_win <= '0;
      r_y   <= '0;
    end else begin
      r_win <= w_elem;
      r_y   <= w_num[NW-1:3];
    end
  end

  assign Y = r_y;
endmodule

// File: tb/tb_cs.sv
// Directed bench for cs with a queue-based reference model checked every cycle.
module tb_cs;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] X = 8'h55;
  logic [9:0] Y;

  int n_tests = 0;
  int n_fail  = 0;

  int hist [9];
  int exp_y = 0;
  bit chk_en = 1'b0;

  cs dut (.clk(clk), .reset(reset), .X(X), .Y(Y));

  always #5 clk = ~clk;

  // Reference model: recompute everything from the window contents each edge.
  always @(posedge clk) begin
    int s, avg, appr;
    if (reset) begin
      for (int k = 0; k < 9; k++) hist[k] = 0;
    end else begin
      for (int k = 8; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = int'(X);
    end
    s = 0;
    for (int k = 0; k < 9; k++) s += hist[k];
    avg = s / 9;
    appr = -1;
    for (int k = 0; k < 9; k++) if (hist[k] <= avg && hist[k] > appr) appr = hist[k];
    exp_y = (s + 9 * appr) / 8;
    chk_en = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_tests++;
      if (int'(Y) !== exp_y) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t Y=%0d expected=%0d", $time, Y, exp_y);
      end
    end
  end

  task automatic step(input logic [7:0] x, input logic rst);
    @(negedge clk);
    X = x;
    reset = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input int want);
    n_tests++;
    if (int'(Y) !== want || exp_y !== want) begin
      n_fail++;
      $display("FAIL %s Y=%0d model=%0d expected=%0d", name, Y, exp_y, want);
    end
  endtask

  initial begin
    @(posedge clk); #1;
    lit("reset_hold0", 0);
    step(8'h55, 1'b1);
    lit("reset_hold1", 0);

    for (int i = 0; i < 9; i++) step(8'h55, 1'b0);
    lit("const_55", 191);

    for (int i = 0; i < 9; i++) step(8'hFF, 1'b0);
    lit("const_ff_max", 573);

    for (int i = 1; i <= 9; i++) step(8'(i), 1'b0);
    lit("ramp_1_9", 11);

    for (int i = 0; i < 8; i++) step(8'd0, 1'b0);
    step(8'd90, 1'b0);
    lit("zeros_then_90", 11);

    for (int i = 1; i <= 9; i++) step(8'(10 * i), 1'b0);
    lit("ramp_10_90", 112);
    step(8'd0, 1'b0);
    lit("shift_in_0", 100);

    step(8'd200, 1'b1);
    lit("mid_reset", 0);
    step(8'd9, 1'b0);
    lit("after_reset_9", 1);
    step(8'd9, 1'b0);
    lit("after_reset_9_9", 2);

    for (int i = 0; i < 40; i++) step(8'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 20; i++) step(8'($urandom_range(250, 255)), 1'b0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
